mole_spawner: RTL

Upstream companion to the whack-a-mole game FSM. It picks a pseudo-random mole on request, drives the one-hot mole LEDs, and times the hit window for the selected difficulty level. It also converts the matching player switch into the single-cycle hit pulse the FSM consumes. Outputs `rng_ready`, `timeout` and `switchx` connect directly to the FSM inputs of the same names; the FSM's `ready_for_mole` and `timeout_start` come back in.

---
 rtl/mole_spawner_if.sv | 27 ++
 rtl/mole_spawner.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mole_spawner_if.sv
// mole_spawner_if: handshake bundle between mole_spawner and the whack-a-mole game FSM
// Toward the spawner : level, ready_for_mole, timeout_start, switches (raw, asynchronous)
// From the spawner   : rng_ready, timeout, switchx, wrong_hit, mole_leds, mole_idx
// Modports: slave = mole_spawner side, master = game FSM / environment side
interface mole_spawner_if #(
    parameter int NUM_MOLES = 8
);
    localparam int IW = $clog2(NUM_MOLES);
    logic [1:0]           level;
    logic                 ready_for_mole;
    logic                 timeout_start;
    logic [NUM_MOLES-1:0] switches;
    logic                 rng_ready;
    logic                 timeout;
    logic                 switchx;
    logic                 wrong_hit;
    logic [NUM_MOLES-1:0] mole_leds;
    logic [IW-1:0]        mole_idx;
    modport slave (
        input  level, ready_for_mole, timeout_start, switches,
        output rng_ready, timeout, switchx, wrong_hit, mole_leds, mole_idx
    );
    modport master (
        output level, ready_for_mole, timeout_start, switches,
        input  rng_ready, timeout, switchx, wrong_hit, mole_leds, mole_idx
    );
endinterface

// File: rtl/mole_spawner.sv
// mole_spawner: picks a pseudo-random mole, lights its LED, times the hit window and turns the lit switch into a hit pulse
// Ports: clk    - system clock
//        reset  - asynchronous active-high reset
//        bus    - mole_spawner_if.slave (level, ready_for_mole, timeout_start, switches in;
//                 rng_ready, timeout, switchx, wrong_hit, mole_leds, mole_idx out)
// Option: define MOLE_NO_REPEAT_EN to forbid the same mole being picked twice in a row
module mole_spawner #(
    parameter int          NUM_MOLES   = 8,
    parameter int          WINDOW_EASY = 150_000_000,
    parameter int          WINDOW_MED  = 100_000_000,
    parameter int          WINDOW_HARD = 50_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic           clk,
    input logic           reset,
    mole_spawner_if.slave bus
);
    localparam int IW   = $clog2(NUM_MOLES);
    localparam int WMAX = (WINDOW_EASY > WINDOW_MED)
                        ? ((WINDOW_EASY > WINDOW_HARD) ? WINDOW_EASY : WINDOW_HARD)
                        : ((WINDOW_MED > WINDOW_HARD) ? WINDOW_MED : WINDOW_HARD);
    localparam int CW   = $clog2(WMAX + 1);

    typedef enum logic [2:0] {IDLE, PICK, PRESENT, ARMED, DONE} state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 hit_q, hit_d;
    logic [NUM_MOLES-1:0] sync1_q, sync2_q, prev_q, edge_q;
    logic [IW-1:0]        cand, pick;
    logic [NUM_MOLES-1:0] lit;
    logic [CW-1:0]        win;
    logic                 hit, present, armed;

    assign cand    = lfsr_q[IW-1:0];
    assign lit     = NUM_MOLES'(1) << idx_q;
    assign hit     = edge_q[idx_q];
    assign present = state_q == PRESENT;
    assign armed   = state_q == ARMED;
    assign win     = bus.level == 2'd0 ? CW'(WINDOW_EASY)
                   : bus.level == 2'd1 ? CW'(WINDOW_MED) : CW'(WINDOW_HARD);

`ifdef MOLE_NO_REPEAT_EN
    logic          last_valid_q;
    logic [IW-1:0] last_idx_q;
    // NUM_MOLES is a power of two, so IW-bit wraparound is the mod
    assign pick = (last_valid_q && cand == last_idx_q) ? IW'(cand + 1'b1) : cand;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_valid_q <= 1'b0;
            last_idx_q   <= '0;
        end else if (state_q == PICK) begin
            last_valid_q <= 1'b1;
            last_idx_q   <= pick;
        end
    end
`else
    assign pick = cand;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ready_for_mole) state_d = PICK;
            PICK:    state_d = PRESENT;
            PRESENT: if (bus.timeout_start) state_d = ARMED;
                     else if (!bus.ready_for_mole) state_d = IDLE;
            ARMED:   if (hit || cnt_q == '0) state_d = DONE;
                     else if (!bus.timeout_start) state_d = IDLE;
            DONE:    if (!bus.timeout_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A hit landing on the counter-zero cycle still reports the window as open
    always_comb begin
        bus.rng_ready = present || armed;
        bus.mole_leds = (present || armed) ? lit : '0;
        bus.timeout   = present || (armed && (cnt_q != '0 || hit)) || (state_q == DONE && hit_q);
        bus.switchx   = armed && hit;
        bus.wrong_hit = armed && |(edge_q & ~lit);
        bus.mole_idx  = idx_q;
    end

    // hit_q remembers how ARMED ended so DONE keeps timeout low only after an expiry
    always_comb begin
        lfsr_d = lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
        cnt_d  = state_q == PICK ? win : (armed && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        idx_d  = state_q == PICK ? pick : idx_q;
        hit_d  = armed ? hit : hit_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            edge_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            sync1_q <= bus.switches;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end
endmodule
